// File: rtl/xunit_sha256_msched.sv
// SHA-256 message-schedule xunit: streams W[0..63] for one block after a run/delay0 start.
// Define XUNIT_MSCHED_KROM_EN to drive out1 with the round constant K[t] from an internal ROM.
module xunit_sha256_msched #(
  parameter int DELAY_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              done,
  input  logic [7:0]        delay0
);

  typedef enum logic [1:0] {IDLE, DELAY, LOAD, EXPAND} state_t;

  state_t              state_reg;
  logic [DELAY_W-1:0]  delay_reg;
  logic [5:0]          t_reg;
  logic [DATA_W-1:0]   win_reg [16];
  logic [DATA_W-1:0]   w_next;
  logic [DATA_W-1:0]   shift_word;
  logic                load_go;
  logic                shift_en;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef XUNIT_MSCHED_KROM_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  // win_reg[15] holds W[t-1], win_reg[0] holds W[t-16]
  assign w_next = ssig1(win_reg[14]) + win_reg[9] + ssig0(win_reg[1]) + win_reg[0];

  // The edge on which an exhausted delay is seen is also the M[0] sample edge,
  // so W[t] lands exactly 1+delay0+t edges after run.
  assign load_go    = (state_reg == LOAD) || ((state_reg == DELAY) && (delay_reg == '0));
  assign shift_en   = load_go || (state_reg == EXPAND);
  assign shift_word = (state_reg == EXPAND) ? w_next : in0;

  assign done = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      delay_reg <= '0;
      t_reg     <= '0;
      out0      <= '0;
`ifdef XUNIT_MSCHED_KROM_EN
      out1      <= '0;
`endif
      for (int i = 0; i < 16; i++) begin
        win_reg[i] <= '0;
      end
    end else if (run) begin
      state_reg <= DELAY;
      delay_reg <= DELAY_W'(delay0);
      t_reg     <= '0;
    end else begin
      if (shift_en) begin
        for (int i = 0; i < 15; i++) begin
          win_reg[i] <= win_reg[i+1];
        end
        win_reg[15] <= shift_word;
        out0        <= shift_word;
        t_reg       <= t_reg + 6'd1;
`ifdef XUNIT_MSCHED_KROM_EN
        out1        <= K_ROM[t_reg];
`endif
      end
      case (state_reg)
        DELAY: begin
          if (delay_reg != '0) begin
            delay_reg <= delay_reg - DELAY_W'(1);
          end else begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (t_reg == 6'd15) begin
            state_reg <= EXPAND;
          end
        end
        EXPAND: begin
          if (t_reg == 6'd63) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifndef XUNIT_MSCHED_KROM_EN
  assign out1 = '0;
`endif

endmodule

// File: tb/tb_xunit_sha256_msched.sv
// Directed bench for xunit_sha256_msched: vector table plus reset, restart and K-ROM sequences.
module tb_xunit_sha256_msched;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [31:0] out1;
  logic        done;
  logic [7:0]  delay0;

  xunit_sha256_msched #(.DELAY_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0),
    .out0(out0), .out1(out1), .done(done), .delay0(delay0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          blk;
    int          dly;
    int          t;
    logic [31:0] exp_w;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] blk_m   [2][16];
  logic [31:0] model_w [64];
  logic [31:0] got_w   [64];
  logic [31:0] got_k   [64];
  vec_t        vecs    [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model(input int blk);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) model_w[i] = blk_m[blk][i];
    for (int i = 16; i < 64; i++) begin
      a = rotr(model_w[i-2], 17) ^ rotr(model_w[i-2], 19) ^ (model_w[i-2] >> 10);
      b = rotr(model_w[i-15], 7) ^ rotr(model_w[i-15], 18) ^ (model_w[i-15] >> 3);
      model_w[i] = a + model_w[i-7] + b + model_w[i-16];
    end
  endtask

  // Issues run, feeds M[t] only on its sample edge, captures out0/out1 for t < stop_at.
  task automatic run_block(input int blk, input int dly, input int stop_at);
    int derr;
    derr = 0;
    @(negedge clk);
    run = 1'b1; delay0 = dly[7:0]; in0 = 32'hDEADBEEF;
    @(posedge clk); #1;
    if (done !== 1'b0) derr++;
    @(negedge clk);
    run = 1'b0;
    in0 = (dly == 0) ? blk_m[blk][0] : 32'hDEADBEEF;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) derr++;
      @(negedge clk);
      in0 = (i == dly - 1) ? blk_m[blk][0] : 32'hDEADBEEF;
    end
    for (int t = 0; t < stop_at; t++) begin
      @(posedge clk); #1;
      got_w[t] = out0;
      got_k[t] = out1;
      if (done !== ((t == 63) ? 1'b1 : 1'b0)) derr++;
      @(negedge clk);
      in0 = (t + 1 < 16) ? blk_m[blk][t+1] : 32'hA5A5A5A5 ^ 32'(t);
    end
    chk($sformatf("done_seq b%0d d%0d", blk, dly), 32'(derr), 32'd0);
  endtask

  task automatic cmp_model(input string nm, input int n);
    int mism;
    mism = 0;
    for (int i = 0; i < n; i++) if (got_w[i] !== model_w[i]) mism++;
    chk(nm, 32'(mism), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kerr;
    int herr;
    for (int i = 0; i < 16; i++) begin
      blk_m[0][i] = 32'h0;
      blk_m[1][i] = 32'hFFFFFFFF;
    end
    blk_m[0][0]  = 32'h61626380;
    blk_m[0][15] = 32'h00000018;

    vecs[0] = '{0, 0, 0,  32'h61626380};
    vecs[1] = '{0, 0, 15, 32'h00000018};
    vecs[2] = '{0, 0, 16, 32'h61626380};
    vecs[3] = '{0, 0, 17, 32'h000F0000};
    vecs[4] = '{0, 5, 16, 32'h61626380};
    vecs[5] = '{0, 5, 17, 32'h000F0000};
    vecs[6] = '{1, 0, 16, 32'h203FFFFC};
    vecs[7] = '{1, 0, 17, 32'h203FFFFC};
    vecs[8] = '{1, 3, 0,  32'hFFFFFFFF};

    rst = 1'b0; run = 1'b0; in0 = '0; delay0 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out0", out0, 32'h0);
    chk("reset out1", out1, 32'h0);
    chk("reset done", {31'b0, done}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_block(vecs[v].blk, vecs[v].dly, 64);
      chk($sformatf("vec%0d W%0d", v, vecs[v].t), got_w[vecs[v].t], vecs[v].exp_w);
      build_model(vecs[v].blk);
      cmp_model($sformatf("vec%0d full64", v), 64);
    end

    // Idle after completion: done stays high, out0 holds W63
    @(posedge clk); #1;
    chk("idle done", {31'b0, done}, 32'd1);
    chk("idle hold", out0, model_w[63]);

    // Round constants from a fresh abc schedule
    run_block(0, 0, 64);
`ifdef XUNIT_MSCHED_KROM_EN
    chk("k0", got_k[0], 32'h428A2F98);
    chk("k16", got_k[16], 32'hE49B69C1);
    chk("k63", got_k[63], 32'hC67178F2);
`else
    kerr = 0;
    for (int i = 0; i < 64; i++) if (got_k[i] !== 32'h0) kerr++;
    chk("k_zero", 32'(kerr), 32'd0);
`endif

    // Restart: run lands on the t=30 edge, new block must begin at M0
    run_block(0, 0, 29);
    build_model(0);
    cmp_model("abort prefix", 29);
    run_block(1, 2, 64);
    chk("restart W0", got_w[0], 32'hFFFFFFFF);
    build_model(1);
    cmp_model("restart full64", 64);

    // Reset mid-EXPAND clears outputs at once and nothing follows without run
    run_block(0, 0, 40);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out0", out0, 32'h0);
    chk("midrst out1", out1, 32'h0);
    chk("midrst done", {31'b0, done}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    herr = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || out0 !== 32'h0) herr++;
    end
    chk("postrst quiet", 32'(herr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
